// File: rtl/z_run_monitor.sv
// z_run_monitor: watches the qualified z stream from the upstream and_ff stage.
// It tracks run length, total ones and edge pulses, and flags when a run of
// ones reaches a programmable threshold. All outputs are registered with one
// cycle of latency from the capturing edge.
module z_run_monitor #(
  parameter int CNT_W = 8,
  parameter int RUN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             z_valid,
  input  logic             z,
  input  logic [RUN_W-1:0] thresh,
  input  logic             clear,
  output logic [RUN_W-1:0] run_len,
  output logic [CNT_W-1:0] ones_cnt,
  output logic             rise,
  output logic             fall,
  output logic             hit,
  output logic             hit_sticky,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HIT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [RUN_W-1:0] run_len_q, run_len_d;
  logic [CNT_W-1:0] ones_cnt_q, ones_cnt_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             hit_q, hit_d;
  logic             hit_sticky_q, hit_sticky_d;
  logic             z_q, z_d;

  logic             sample;
  logic             reach;

  // Saturating increment of the run-length counter (holds at all-ones).
  function automatic logic [RUN_W-1:0] sat_inc_run(input logic [RUN_W-1:0] v);
    return (v == {RUN_W{1'b1}}) ? v : v + RUN_W'(1);
  endfunction

  // Saturating increment of the total-ones counter (holds at all-ones).
  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign sample = z_valid & ~clear;

  // Threshold test done one bit wider so a saturated run_len cannot wrap
  // to zero when incremented; a zero thresh disables detection.
  assign reach = (thresh != '0) &&
                 (({1'b0, run_len_q} + (RUN_W+1)'(1)) >= {1'b0, thresh});

  // Next-state and next-output computation for every register.
  always_comb begin
    state_d      = state_q;
    run_len_d    = run_len_q;
    ones_cnt_d   = ones_cnt_q;
    z_d          = z_q;
    hit_sticky_d = hit_sticky_q;
    rise_d       = 1'b0;
    fall_d       = 1'b0;
    hit_d        = 1'b0;

    if (clear) begin
      state_d      = IDLE;
      run_len_d    = '0;
      ones_cnt_d   = '0;
      z_d          = 1'b0;
      hit_sticky_d = 1'b0;
    end else if (sample) begin
      z_d    = z;
      rise_d = z & ~z_q;
      fall_d = ~z & z_q;
      if (z) begin
        run_len_d  = sat_inc_run(run_len_q);
        ones_cnt_d = sat_inc_cnt(ones_cnt_q);
      end else begin
        run_len_d = '0;
      end

      case (state_q)
        IDLE: begin
          if (z) begin
            if (thresh == RUN_W'(1)) begin
              state_d = HIT;
              hit_d   = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (!z) begin
            state_d = IDLE;
          end else if (reach) begin
            state_d = HIT;
            hit_d   = 1'b1;
          end
        end
        HIT: begin
          if (!z) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

      hit_sticky_d = hit_sticky_q | hit_d;
    end
  end

  // Registered state and outputs; reset forces everything idle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      run_len_q    <= '0;
      ones_cnt_q   <= '0;
      z_q          <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      hit_q        <= 1'b0;
      hit_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_len_q    <= run_len_d;
      ones_cnt_q   <= ones_cnt_d;
      z_q          <= z_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      hit_q        <= hit_d;
      hit_sticky_q <= hit_sticky_d;
    end
  end

  assign run_len    = run_len_q;
  assign ones_cnt   = ones_cnt_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign hit        = hit_q;
  assign hit_sticky = hit_sticky_q;
  assign state      = state_q;

endmodule

// File: tb/tb_z_run_monitor.sv
// Directed bench for z_run_monitor: each driven sample pushes its expected
// outputs onto a scoreboard queue, popped and compared after the capture edge.
module tb_z_run_monitor;

  logic       clk;
  logic       rst_n;
  logic       z_valid;
  logic       z;
  logic [3:0] thresh;
  logic       clear;
  logic [3:0] run_len;
  logic [7:0] ones_cnt;
  logic       rise;
  logic       fall;
  logic       hit;
  logic       hit_sticky;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  int step_no = 0;

  typedef struct {
    int run;
    int ones;
    int rise;
    int fall;
    int hit;
    int sticky;
    int st;
  } exp_t;

  exp_t sb[$];

  // Reference model: unsaturated counters, saturation applied on readout.
  int m_run_raw = 0;
  int m_ones_raw = 0;
  int m_z = 0;
  int m_sticky = 0;
  int m_state = 0;
  int m_rise = 0;
  int m_fall = 0;
  int m_hit = 0;

  z_run_monitor #(.CNT_W(8), .RUN_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .z_valid    (z_valid),
    .z          (z),
    .thresh     (thresh),
    .clear      (clear),
    .run_len    (run_len),
    .ones_cnt   (ones_cnt),
    .rise       (rise),
    .fall       (fall),
    .hit        (hit),
    .hit_sticky (hit_sticky),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic exp_t model_snapshot();
    exp_t e;
    e.run    = (m_run_raw > 15) ? 15 : m_run_raw;
    e.ones   = (m_ones_raw > 255) ? 255 : m_ones_raw;
    e.rise   = m_rise;
    e.fall   = m_fall;
    e.hit    = m_hit;
    e.sticky = m_sticky;
    e.st     = m_state;
    return e;
  endfunction

  task automatic model_reset();
    m_run_raw = 0; m_ones_raw = 0; m_z = 0; m_sticky = 0;
    m_state = 0; m_rise = 0; m_fall = 0; m_hit = 0;
  endtask

  task automatic model_step(input int v, input int zz, input int cl, input int th);
    int prev;
    m_rise = 0; m_fall = 0; m_hit = 0;
    if (cl != 0) begin
      model_reset();
    end else if (v != 0) begin
      m_rise = (zz == 1 && m_z == 0) ? 1 : 0;
      m_fall = (zz == 0 && m_z == 1) ? 1 : 0;
      m_z = zz;
      prev = m_state;
      if (zz == 1) begin
        m_run_raw++;
        m_ones_raw++;
        if (prev == 2) m_state = 2;
        else if (th != 0 && m_run_raw >= th) m_state = 2;
        else m_state = 1;
      end else begin
        m_run_raw = 0;
        m_state = 0;
      end
      m_hit = (m_state == 2 && prev != 2) ? 1 : 0;
      if (m_hit == 1) m_sticky = 1;
    end
  endtask

  task automatic compare_all(input string pfx);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard observed empty expected entry", pfx);
      return;
    end
    e = sb.pop_front();
    chk({pfx, " run_len"},    32'(run_len),    32'(e.run));
    chk({pfx, " ones_cnt"},   32'(ones_cnt),   32'(e.ones));
    chk({pfx, " rise"},       32'(rise),       32'(e.rise));
    chk({pfx, " fall"},       32'(fall),       32'(e.fall));
    chk({pfx, " hit"},        32'(hit),        32'(e.hit));
    chk({pfx, " hit_sticky"}, 32'(hit_sticky), 32'(e.sticky));
    chk({pfx, " state"},      32'(state),      32'(e.st));
  endtask

  // Drive one cycle of stimulus on the falling edge, check after the rising edge.
  task automatic step(input int v, input int zz, input int cl);
    @(negedge clk);
    z_valid = v[0];
    z       = zz[0];
    clear   = cl[0];
    model_step(v, zz, cl, int'(thresh));
    sb.push_back(model_snapshot());
    @(posedge clk);
    #1;
    step_no++;
    compare_all($sformatf("step%0d", step_no));
  endtask

  task automatic check_all_zero(input string pfx);
    chk({pfx, " run_len"},    32'(run_len),    0);
    chk({pfx, " ones_cnt"},   32'(ones_cnt),   0);
    chk({pfx, " rise"},       32'(rise),       0);
    chk({pfx, " fall"},       32'(fall),       0);
    chk({pfx, " hit"},        32'(hit),        0);
    chk({pfx, " hit_sticky"}, 32'(hit_sticky), 0);
    chk({pfx, " state"},      32'(state),      0);
  endtask

  initial begin
    rst_n = 1'b0; z_valid = 1'b0; z = 1'b0; thresh = 4'd0; clear = 1'b0;
    #2;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Threshold 3: four ones then a zero.
    thresh = 4'd3;
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 1, 0);
    chk("t3 hit third", 32'(hit), 1);
    chk("t3 state third", 32'(state), 2);
    step(1, 1, 0);
    step(1, 0, 0);
    chk("t3 ones_cnt", 32'(ones_cnt), 4);
    chk("t3 fall", 32'(fall), 1);

    // Threshold 2 with invalid cycles interleaved.
    step(0, 0, 1);
    thresh = 4'd2;
    step(1, 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    chk("t2 run hold", 32'(run_len), 1);
    step(1, 1, 0);
    chk("t2 hit", 32'(hit), 1);

    // Detection disabled: run_len saturates, state stays RUN.
    step(0, 0, 1);
    thresh = 4'd0;
    for (int i = 0; i < 20; i++) step(1, 1, 0);
    chk("t0 run sat", 32'(run_len), 15);
    chk("t0 ones", 32'(ones_cnt), 20);
    chk("t0 state", 32'(state), 1);

    // 300 ones with thresh 1: immediate hit, ones_cnt saturates.
    step(0, 0, 1);
    thresh = 4'd1;
    step(1, 1, 0);
    chk("t1 hit first", 32'(hit), 1);
    for (int i = 1; i < 300; i++) step(1, 1, 0);
    chk("t1 ones sat", 32'(ones_cnt), 255);
    chk("t1 sticky", 32'(hit_sticky), 1);

    // Clear beats a simultaneous valid sample.
    thresh = 4'd5;
    step(1, 0, 0);
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 1, 1);
    chk("clr state", 32'(state), 0);
    chk("clr rise", 32'(rise), 0);

    // Asynchronous reset mid-run, pulse of 3 ns between clock edges.
    step(1, 1, 0);
    step(1, 1, 0);
    chk("pre-rst run", 32'(run_len), 2);
    @(negedge clk);
    z_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_all_zero("async rst");
    #2 rst_n = 1'b1;
    model_reset();
    step(1, 1, 0);
    chk("post-rst rise", 32'(rise), 1);
    chk("post-rst run", 32'(run_len), 1);

    // Lowering thresh while in RUN takes effect on the next sample.
    step(0, 0, 1);
    thresh = 4'd8;
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 1, 0);
    thresh = 4'd2;
    step(1, 1, 0);
    chk("lower hit", 32'(hit), 1);
    thresh = 4'd0;
    step(1, 1, 0);
    step(1, 0, 0);
    chk("sticky idle", 32'(hit_sticky), 1);
    step(0, 1, 0);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard leftover observed %0d expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/z_run_monitor.md
Z_RUN_MONITOR -- requirements
Module: z_run_monitor

Interface
REQ-001 Parameter: CNT_W, 8, width of total-ones counter ones_cnt.
REQ-002 Parameter: RUN_W, 4, width of run-length counter run_len and of thresh.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: z_valid  input  1  qualifier; z is sampled only when high (driven from the upstream and_ff enable, delayed one cycle).
REQ-006 Port: z  input  1  registered output of the upstream and_ff stage.
REQ-007 Port: thresh  input  RUN_W  run length that triggers a hit; 0 = detection disabled.
REQ-008 Port: clear  input  1  synchronous clear of all state.
REQ-009 Port: run_len  output  RUN_W  current count of consecutive sampled ones.
REQ-010 Port: ones_cnt  output  CNT_W  total sampled ones since reset/clear.
REQ-011 Port: rise  output  1  one-cycle pulse on sampled 0->1 transition.
REQ-012 Port: fall  output  1  one-cycle pulse on sampled 1->0 transition.
REQ-013 Port: hit  output  1  one-cycle pulse on entry to HIT.
REQ-014 Port: hit_sticky  output  1  set with hit; held until clear or reset.
REQ-015 Port: state  output  2  FSM state encoding: IDLE=0, RUN=1, HIT=2.

Function
REQ-016 A valid sample is a rising edge with z_valid=1 and clear=0; cycles without a valid sample SHALL hold all state, and rise, fall, and hit SHALL be 0.
REQ-017 All outputs SHALL be registered and SHALL reflect a valid sample on the cycle after the edge that captures it (latency 1).
REQ-018 Internal z_q SHALL hold the last sampled z: rise = z & ~z_q, fall = ~z & z_q, both evaluated only on a valid sample.
REQ-019 ones_cnt SHALL increment on each valid z=1 and saturate at 2^CNT_W-1, with no wrap.
REQ-020 run_len SHALL increment on valid z=1 and saturate at 2^RUN_W-1; valid z=0 SHALL set it to 0.
REQ-021 FSM IDLE: on valid z=1, go to HIT if thresh==1, otherwise go to RUN; on valid z=0, stay in IDLE.
REQ-022 FSM RUN: on valid z=0, go to IDLE; on valid z=1 with thresh!=0 and (run_len+1)>=thresh, go to HIT; otherwise stay in RUN.
REQ-023 FSM HIT: on valid z=0, go to IDLE; on valid z=1, stay in HIT with no further hit pulse.
REQ-024 thresh=0: the FSM SHALL never enter HIT; IDLE/RUN tracking still operates.
REQ-025 thresh SHALL be compared live on every valid sample; a change takes effect on the next valid sample, including a lowered thresh while in RUN.
REQ-026 Saturated run_len SHALL still compare correctly, with no wrap.
REQ-027 clear=1 SHALL take priority over a simultaneous valid sample: counters, z_q, and hit_sticky go to 0, state goes to IDLE, pulses are 0, and the sample is discarded.
REQ-028 hit and hit_sticky set in the same cycle; hit_sticky SHALL survive later returns to IDLE.

Reset
REQ-029 rst_n=0 SHALL asynchronously force run_len=0, ones_cnt=0, rise=0, fall=0, hit=0, hit_sticky=0, state=IDLE, and z_q=0.
REQ-030 Reset asserted mid-run SHALL abort immediately; after release, the first valid z=1 SHALL produce rise=1.
REQ-031 No output SHALL change on the reset deassertion edge; sampling resumes on the first rising clk with rst_n=1.

Verification
REQ-032 thresh=3, z_valid=1, z=1,1,1,1,0 -> run_len 1,2,3,4,0; state RUN,RUN,HIT,HIT,IDLE; hit on the 3rd sample only; rise on the 1st; fall on the 5th; ones_cnt=4.
REQ-033 thresh=2, z=1 with z_valid=1,0,0,1 -> run_len holds at 1 across invalid cycles; hit on the 2nd valid sample; no pulses on invalid cycles.
REQ-034 thresh=0, 20 valid ones -> run_len saturates at 15, state stays RUN, hit never asserts, ones_cnt=20.
REQ-035 300 valid ones, thresh=1 -> hit on the 1st sample; ones_cnt saturates at 255; hit_sticky=1.
REQ-036 Valid z=1 with clear=1 in the same cycle after run_len=2 -> all counters 0, state IDLE, rise=0, hit_sticky=0.
REQ-037 rst_n pulled low for 3 ns mid-run (run_len=2, state RUN) -> outputs zero immediately, without a clock edge; next valid z=1 -> rise=1, run_len=1.
